vga_display_core: RTL and testbench
===================================

VGA_DISPLAY_CORE -- requirements
Module: vga_display_core

Interface
REQ-001 The block SHALL have a single clock and a reset: one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL expose these parameters, one per line as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- CLK_DIV, 4, clk cycles per pixel; legal range 1..16.
- RGB_W, 3, colour bus width.
- PIPE_LAT, 1, pixel ticks from coordinate to valid rgb_in; legal range 0..4.
- SYNC_POL, 0, sync active level (0 = active-low).
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- rgb_in, in, RGB_W, colour from the pixel generator, valid PIPE_LAT ticks after its coordinate.
- p_tick, out, 1, one-clk pixel strobe.
- pixel_x, out, 10, current horizontal count.
- pixel_y, out, 10, current vertical count.
- video_on, out, 1, coordinate is in the active area (undelayed).
- frame_start, out, 1, one-clk pulse at the start of a frame.
- hsync, out, 1, aligned horizontal sync.
- vsync, out, 1, aligned vertical sync.
- rgb, out, RGB_W, aligned, blanked colour.
REQ-004 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL each be ≤1024; illegal parameters SHALL stop elaboration.

Function
REQ-005 The divider counter SHALL count 0..CLK_DIV-1 and wrap.
REQ-006 p_tick SHALL be high for one clk when the divider equals CLK_DIV-1; when CLK_DIV=1, p_tick SHALL be constantly high.
REQ-007 pixel_x SHALL advance on each p_tick and wrap from H_TOTAL-1 to 0.
REQ-008 pixel_y SHALL advance only on the p_tick where pixel_x wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-009 video_on SHALL equal (pixel_x<H_ACTIVE && pixel_y<V_ACTIVE), with no added delay.
REQ-010 Raw hsync SHALL be active for H_ACTIVE+H_FP ≤ pixel_x ≤ H_ACTIVE+H_FP+H_SYNC-1.
REQ-011 Raw vsync SHALL be active for V_ACTIVE+V_FP ≤ pixel_y ≤ V_ACTIVE+V_FP+V_SYNC-1.
REQ-012 Active level of both syncs SHALL be SYNC_POL.
REQ-013 Raw hsync, raw vsync and video_on SHALL pass through a shift register of PIPE_LAT+1 stages that advances only on p_tick.
REQ-014 hsync and vsync SHALL be the final stage of that shift register, registered.
REQ-015 On p_tick, rgb SHALL load rgb_in if the delayed video_on stage is 1, otherwise 0; between ticks, rgb SHALL hold.
REQ-016 The sync, blanking and colour alignment to one coordinate SHALL be exact for every legal PIPE_LAT.
REQ-017 frame_start SHALL be high for one clk exactly when p_tick=1, pixel_x=0 and pixel_y=0.
REQ-018 The simultaneous wrap of x and y (H_TOTAL-1, V_TOTAL-1) SHALL take both counters to 0 on the same p_tick.
REQ-019 All outputs SHALL be driven from registers, except p_tick, video_on and frame_start, which are decoded from registers only.

Reset
REQ-020 While reset=1, the block SHALL hold: divider=0, pixel_x=0, pixel_y=0, p_tick=0, frame_start=0, rgb=0.
REQ-021 While reset=1, hsync and vsync SHALL sit at the inactive level (~SYNC_POL).
REQ-022 While reset=1, every delay stage SHALL be loaded with inactive sync and video_on=0.
REQ-023 These reset values SHALL take effect asynchronously, including mid-line or mid-frame.
REQ-024 After release, the first p_tick SHALL occur CLK_DIV clks later, and scanning SHALL restart at (0,0).

Verification
REQ-025 Defaults, reset released at t0 -> p_tick high at clk t0+3, then every 4 clks; frame_start period 1,680,000 clks.
REQ-026 Defaults -> hsync low for exactly 384 clks per line, falling on the 2nd p_tick after pixel_x becomes 656; vsync low for 2 lines (6400 clks) per frame.
REQ-027 Defaults, rgb_in held 3'b111 -> rgb=3'b111 for 640 consecutive ticks per line on 480 lines, and 0 otherwise; the first 3'b111 appears 2 ticks after (0,0).
REQ-028 PIPE_LAT=3, rgb_in = pixel_x[2:0] (fed back combinationally, delayed 3 ticks by the bench) -> rgb sequence on each line starts 0,1,2…, and hsync falls 4 ticks after pixel_x=656.
REQ-029 Reset asserted at pixel_x=300, pixel_y=100 -> in the same clk: hsync=1, vsync=1, rgb=0, pixel_x=0, pixel_y=0; after release, a normal frame restarts from (0,0).
REQ-030 H=8/1/2/1, V=4/1/1/1, CLK_DIV=1, SYNC_POL=1, PIPE_LAT=0 -> 12-tick lines; hsync high for 2 ticks starting 1 tick after pixel_x=9; frame of 84 clks.

Source files
------------

// File: rtl/vga_display_core.sv
// VGA timing core: pixel-rate divider, x/y scan counters and a sync/blank delay
// line that keeps hsync, vsync and rgb aligned with a pipelined pixel source.
module vga_display_core #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 4,
    parameter int   RGB_W    = 3,
    parameter int   PIPE_LAT = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             p_tick,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic             video_on,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16 ||
        PIPE_LAT < 0 || PIPE_LAT > 4 || RGB_W < 1) begin : g_param_check
        $error("vga_display_core: illegal parameter set");
    end

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
    localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic von;
    } stage_t;

    localparam stage_t STAGE_IDLE = stage_t'{~SYNC_POL, ~SYNC_POL, 1'b0};

    logic [3:0]       r_div;
    logic             r_run;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    stage_t           r_pipe [0:PIPE_LAT];
    logic [RGB_W-1:0] r_rgb;
    stage_t           w_raw;
    stage_t           w_stage_in [0:PIPE_LAT];

    // NOTE: r_run keeps p_tick low through reset even when CLK_DIV=1 pins r_div at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run <= 1'b0;
            r_div <= '0;
        end else begin
            r_run <= 1'b1;
            r_div <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
        end
    end

    assign p_tick = r_run & (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (p_tick) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    assign video_on    = ({1'b0, r_x} < X_ACT) && ({1'b0, r_y} < Y_ACT);
    assign frame_start = p_tick && (r_x == 10'd0) && (r_y == 10'd0);

    // The colour register loads from the value entering the final stage so rgb
    // changes on the same tick as the syncs of the same coordinate.
    always_comb begin
        w_raw.hs  = (r_x >= HS_FIRST && r_x <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        w_raw.vs  = (r_y >= VS_FIRST && r_y <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        w_raw.von = video_on;
        w_stage_in[0] = w_raw;
        for (int k = 1; k <= PIPE_LAT; k++) begin
            w_stage_in[k] = r_pipe[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= PIPE_LAT; k++) begin
                r_pipe[k] <= STAGE_IDLE;
            end
            r_rgb <= '0;
        end else if (p_tick) begin
            for (int k = 0; k <= PIPE_LAT; k++) begin
                r_pipe[k] <= w_stage_in[k];
            end
            r_rgb <= w_stage_in[PIPE_LAT].von ? rgb_in : '0;
        end
    end

    assign pixel_x = r_x;
    assign pixel_y = r_y;
    assign hsync   = r_pipe[PIPE_LAT].hs;
    assign vsync   = r_pipe[PIPE_LAT].vs;
    assign rgb     = r_rgb;

endmodule

// File: tb/tb_vga_display_core.sv
// Bench for vga_display_core: three configurations checked against a tick-count
// model through a latency-aware expectation queue, plus direct timing probes.
`timescale 1ns/1ps
module tb_vga_display_core;

    localparam int N = 3;
    // dut0: default H, short V, PIPE_LAT=1, CLK_DIV=4, rgb_in=111
    // dut1: default H, short V, PIPE_LAT=3, CLK_DIV=1, rgb_in=pixel_x delayed 3 ticks
    // dut2: 8/1/2/1 x 4/1/1/1, CLK_DIV=1, SYNC_POL=1, PIPE_LAT=0, rgb_in=pixel_x
    localparam int   HT  [N] = '{800, 800, 12};
    localparam int   VT  [N] = '{8, 7, 7};
    localparam int   HA  [N] = '{640, 640, 8};
    localparam int   VA  [N] = '{4, 4, 4};
    localparam int   HSF [N] = '{656, 656, 9};
    localparam int   HSW [N] = '{96, 96, 2};
    localparam int   VSF [N] = '{5, 5, 5};
    localparam int   VSW [N] = '{2, 1, 1};
    localparam int   DIV [N] = '{4, 1, 1};
    localparam int   PL  [N] = '{1, 3, 0};
    localparam logic POL [N] = '{1'b0, 1'b0, 1'b1};

    typedef struct {
        int         due;
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst    [N] = '{1'b1, 1'b1, 1'b1};
    logic [2:0] rgb_in [N];
    logic       pt [N];
    logic       vo [N];
    logic       fs [N];
    logic       hs [N];
    logic       vs [N];
    logic [9:0] px [N];
    logic [9:0] py [N];
    logic [2:0] rgb [N];
    logic [9:0] dl [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_display_core #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_dut0 (
        .clk(clk), .reset(rst[0]), .rgb_in(rgb_in[0]), .p_tick(pt[0]),
        .pixel_x(px[0]), .pixel_y(py[0]), .video_on(vo[0]), .frame_start(fs[0]),
        .hsync(hs[0]), .vsync(vs[0]), .rgb(rgb[0])
    );

    vga_display_core #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .PIPE_LAT(3)
    ) u_dut1 (
        .clk(clk), .reset(rst[1]), .rgb_in(rgb_in[1]), .p_tick(pt[1]),
        .pixel_x(px[1]), .pixel_y(py[1]), .video_on(vo[1]), .frame_start(fs[1]),
        .hsync(hs[1]), .vsync(vs[1]), .rgb(rgb[1])
    );

    vga_display_core #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .PIPE_LAT(0), .SYNC_POL(1'b1)
    ) u_dut2 (
        .clk(clk), .reset(rst[2]), .rgb_in(rgb_in[2]), .p_tick(pt[2]),
        .pixel_x(px[2]), .pixel_y(py[2]), .video_on(vo[2]), .frame_start(fs[2]),
        .hsync(hs[2]), .vsync(vs[2]), .rgb(rgb[2])
    );

    // Pixel source with three ticks of latency for dut1.
    always @(posedge clk) begin
        if (pt[1] === 1'b1) begin
            dl[0] <= px[1];
            dl[1] <= dl[0];
            dl[2] <= dl[1];
        end
    end

    assign rgb_in[0] = 3'b111;
    assign rgb_in[1] = dl[2][2:0];
    assign rgb_in[2] = px[2][2:0];

    function automatic exp_t expect_at(input int d, input int n);
        int   x;
        int   y;
        logic von;
        exp_t e;
        x     = n % HT[d];
        y     = (n / HT[d]) % VT[d];
        von   = (x < HA[d]) && (y < VA[d]);
        e.due = n + PL[d];
        e.hs  = (x >= HSF[d] && x < HSF[d] + HSW[d]) ? POL[d] : ~POL[d];
        e.vs  = (y >= VSF[d] && y < VSF[d] + VSW[d]) ? POL[d] : ~POL[d];
        e.rgb = !von ? 3'd0 : (d == 0) ? 3'b111 : 3'(x % 8);
        return e;
    endfunction

    task automatic apply_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        repeat (2) @(negedge clk);
        rst[d] = 1'b0;
    endtask

    // Starts at the negedge where reset was released; tick n shows coordinate n.
    task automatic run_scoreboard(input int d, input int n_ticks);
        exp_t q[$];
        exp_t e;
        int   n = 0;
        int   last = -1;
        int   gap = 0;
        int   exp_gap;
        int   ex;
        int   ey;
        int   budget;
        logic evo;
        logic efs;
        budget = (n_ticks + 8) * DIV[d] + 16;
        while ((n < n_ticks || q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            gap++;
            while (q.size() != 0 && q[0].due == last) begin
                e = q.pop_front();
                checks++;
                if ({hs[d], vs[d], rgb[d]} !== {e.hs, e.vs, e.rgb}) begin
                    errors++;
                    $display("FAIL sb_out dut%0d tick %0d: hs/vs/rgb got %b/%b/%0d want %b/%b/%0d",
                             d, last, hs[d], vs[d], rgb[d], e.hs, e.vs, e.rgb);
                end
            end
            if (pt[d] === 1'b1) begin
                if (n < n_ticks) begin
                    ex  = n % HT[d];
                    ey  = (n / HT[d]) % VT[d];
                    evo = (ex < HA[d]) && (ey < VA[d]);
                    efs = (ex == 0) && (ey == 0);
                    checks++;
                    if ({px[d], py[d], vo[d], fs[d]} !== {10'(ex), 10'(ey), evo, efs}) begin
                        errors++;
                        $display("FAIL sb_coord dut%0d tick %0d: x/y/von/fs got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                                 d, n, px[d], py[d], vo[d], fs[d], ex, ey, evo, efs);
                    end
                    exp_gap = (n != 0) ? DIV[d] : (DIV[d] == 1) ? 1 : DIV[d] - 1;
                    checks++;
                    if (gap != exp_gap) begin
                        errors++;
                        $display("FAIL sb_tick_gap dut%0d tick %0d: got %0d clks want %0d", d, n, gap, exp_gap);
                    end
                    q.push_back(expect_at(d, n));
                end
                last = n;
                n++;
                gap = 0;
            end
        end
        if (n < n_ticks || q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_timeout dut%0d: ticks %0d of %0d, %0d pending", d, n, n_ticks, q.size());
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checks++;
            if ({pt[d], fs[d], px[d], py[d], rgb[d], hs[d], vs[d]} !==
                {1'b0, 1'b0, 10'd0, 10'd0, 3'd0, ~POL[d], ~POL[d]}) begin
                errors++;
                $display("FAIL reset_state dut%0d: pt/fs/x/y/rgb/hs/vs got %b/%b/%0d/%0d/%0d/%b/%b",
                         d, pt[d], fs[d], px[d], py[d], rgb[d], hs[d], vs[d]);
            end
        end
    endtask

    task automatic test_default_frame;
        apply_reset(0);
        run_scoreboard(0, HT[0] * VT[0] + 4);
    endtask

    task automatic test_pipe3;
        apply_reset(1);
        run_scoreboard(1, HT[1] * VT[1] + 4);
    endtask

    task automatic test_small_frame;
        apply_reset(2);
        run_scoreboard(2, 2 * HT[2] * VT[2] + 3);
    endtask

    task automatic test_hsync_align(input int d);
        int budget;
        int cnt = 0;
        int w = 0;
        apply_reset(d);
        budget = 2 * HT[d] * DIV[d];
        while (px[d] !== 10'(HSF[d]) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        while (hs[d] !== POL[d] && budget > 0) begin
            if (pt[d] === 1'b1) cnt++;
            @(negedge clk);
            budget--;
        end
        while (hs[d] === POL[d] && budget > 0) begin
            @(negedge clk);
            w++;
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL hsync_timeout dut%0d: no complete hsync pulse", d);
        end
        checks++;
        if (cnt != PL[d] + 1) begin
            errors++;
            $display("FAIL hsync_delay dut%0d: got %0d ticks want %0d", d, cnt, PL[d] + 1);
        end
        checks++;
        if (w != HSW[d] * DIV[d]) begin
            errors++;
            $display("FAIL hsync_width dut%0d: got %0d clks want %0d", d, w, HSW[d] * DIV[d]);
        end
    endtask

    task automatic test_frame_period(input int d);
        int budget = 4 * HT[d] * VT[d] * DIV[d];
        int period = 0;
        int vsa = 0;
        apply_reset(d);
        while (fs[d] !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        period = 1;
        while (fs[d] !== 1'b1 && budget > 0) begin
            if (vs[d] === POL[d]) vsa++;
            @(negedge clk);
            period++;
            budget--;
        end
        checks++;
        if (budget == 0 || period != HT[d] * VT[d] * DIV[d]) begin
            errors++;
            $display("FAIL frame_period dut%0d: got %0d clks want %0d", d, period, HT[d] * VT[d] * DIV[d]);
        end
        checks++;
        if (vsa != VSW[d] * HT[d] * DIV[d]) begin
            errors++;
            $display("FAIL vsync_width dut%0d: got %0d clks want %0d", d, vsa, VSW[d] * HT[d] * DIV[d]);
        end
    endtask

    task automatic test_reset_async(input int d, input int x, input int y);
        int budget = HT[d] * VT[d] * DIV[d] + 16;
        apply_reset(d);
        while (!(px[d] === 10'(x) && py[d] === 10'(y)) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL async_reach dut%0d: never reached (%0d,%0d)", d, x, y);
        end
        #2 rst[d] = 1'b1;
        #1;
        checks++;
        if ({pt[d], fs[d], px[d], py[d], rgb[d], hs[d], vs[d]} !==
            {1'b0, 1'b0, 10'd0, 10'd0, 3'd0, ~POL[d], ~POL[d]}) begin
            errors++;
            $display("FAIL async_reset dut%0d: pt/fs/x/y/rgb/hs/vs got %b/%b/%0d/%0d/%0d/%b/%b",
                     d, pt[d], fs[d], px[d], py[d], rgb[d], hs[d], vs[d]);
        end
        @(negedge clk);
        rst[d] = 1'b0;
        run_scoreboard(d, 2 * HT[d]);
    endtask

    initial begin
        test_reset;
        test_default_frame;
        test_hsync_align(0);
        test_pipe3;
        test_hsync_align(1);
        test_reset_async(1, 700, 5);
        test_small_frame;
        test_hsync_align(2);
        test_frame_period(2);
        test_reset_async(2, 5, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
